// File: rtl/dsp_capture_mem_pkg.sv
// Shared types, default sizes and width helpers for the ADC snapshot capture memory.
package dsp_capture_mem_pkg;

    localparam int ADC_WIDTH_DEF    = 6;
    localparam int WAY_WIDTH_DEF    = 16;
    localparam int NUM_BANKS_DEF    = 4;
    localparam int BANK_DEPTH_DEF   = 32;
    localparam int FRAME_LENGTH_DEF = 128;
    localparam int MEM_WIDTH_DEF    = ADC_WIDTH_DEF * WAY_WIDTH_DEF;

    localparam int ADDR_W = $clog2(NUM_BANKS_DEF * BANK_DEPTH_DEF);
    localparam int BIT_W  = $clog2(MEM_WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FULL    = 2'd2,
        READ    = 2'd3
    } state_e;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dsp_capture_mem_bank.sv
// One bank of capture storage: single-port RAM with synchronous write and registered read.
module mem_bank #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 96,
    parameter int AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Contents are deliberately not reset; only the control path is.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dsp_capture_mem.sv
// Snapshot capture of parallel ADC words into banked RAM, replayed serially LSB first.
module dsp_capture_mem
    import dsp_capture_mem_pkg::*;
#(
    parameter int ADC_WIDTH    = ADC_WIDTH_DEF,
    parameter int WAY_WIDTH    = WAY_WIDTH_DEF,
    parameter int NUM_BANKS    = NUM_BANKS_DEF,
    parameter int BANK_DEPTH   = BANK_DEPTH_DEF,
    parameter int FRAME_LENGTH = FRAME_LENGTH_DEF
) (
    input  logic                                i_clk_dig_mem,
    input  logic                                i_rstb,
    input  logic [WAY_WIDTH-1:0][ADC_WIDTH-1:0] i_dat_mem,
    input  logic                                i_capture_start,
    input  logic                                i_read_start,
    output logic                                o_bit_read_mem,
    output logic                                o_bit_valid,
    output logic                                o_capture_done,
    output logic                                o_busy,
    output state_e                              o_dbg_state
);

    localparam int MEM_WIDTH = ADC_WIDTH * WAY_WIDTH;
    localparam int AW        = idx_width(NUM_BANKS * BANK_DEPTH);
    localparam int RW        = idx_width(BANK_DEPTH);
    localparam int BKW       = idx_width(NUM_BANKS);
    localparam int BW        = idx_width(MEM_WIDTH);

    state_e                 state_q, state_d;
    logic [AW-1:0]          waddr_q, waddr_d;
    logic [AW-1:0]          word_q, word_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [MEM_WIDTH-1:0]   shift_q, shift_d;
    logic                   valid_q, valid_d;
    logic                   prime_q, prime_d;
    logic                   done_q, done_d;
    logic [BKW-1:0]         bsel_q, bsel_d;

    logic [AW-1:0]          rd_addr, mem_addr;
    logic [RW-1:0]          mem_row;
    logic                   mem_we;
    logic [MEM_WIDTH-1:0]   wdata, rd_word;
    logic [MEM_WIDTH-1:0]   rdata [NUM_BANKS];

    // While shifting word n the RAM already holds word n+1 on its output, so loads never stall.
    assign rd_addr  = valid_q ? (word_q + AW'(1)) : '0;
    assign mem_we   = (state_q == CAPTURE);
    assign mem_addr = mem_we ? waddr_q : rd_addr;
    assign mem_row  = mem_addr[RW-1:0];
    assign bsel_d   = BKW'(mem_addr >> RW);
    assign wdata    = i_dat_mem;
    assign rd_word  = rdata[bsel_q];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DEPTH (BANK_DEPTH),
            .WIDTH (MEM_WIDTH),
            .AW    (RW)
        ) u_bank (
            .clk_i   (i_clk_dig_mem),
            .we_i    (mem_we && (bsel_d == BKW'(g))),
            .addr_i  (mem_row),
            .wdata_i (wdata),
            .rdata_o (rdata[g])
        );
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        word_d  = word_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = valid_q;
        prime_d = 1'b0;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                if (i_capture_start) begin
                    state_d = CAPTURE;
                    waddr_d = '0;
                end
            end
            FULL: begin
                done_d = 1'b1;
                if (i_capture_start) begin
                    state_d = CAPTURE;
                    waddr_d = '0;
                    done_d  = 1'b0;
                end else if (i_read_start) begin
                    state_d = READ;
                    word_d  = '0;
                    bit_d   = '0;
                    prime_d = 1'b1;
                end
            end
            CAPTURE: begin
                waddr_d = waddr_q + AW'(1);
                if (waddr_q == AW'(FRAME_LENGTH - 1)) begin
                    state_d = FULL;
                end
            end
            READ: begin
                // prime_q covers the RAM read latency before the first word can be loaded.
                if (prime_q) begin
                    valid_d = 1'b0;
                end else if (!valid_q) begin
                    shift_d = rd_word;
                    valid_d = 1'b1;
                end else if (bit_q == BW'(MEM_WIDTH - 1)) begin
                    bit_d = '0;
                    if (word_q == AW'(FRAME_LENGTH - 1)) begin
                        valid_d = 1'b0;
                        shift_d = '0;
                        state_d = FULL;
                    end else begin
                        shift_d = rd_word;
                        word_d  = word_q + AW'(1);
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk_dig_mem or negedge i_rstb) begin
        if (!i_rstb) begin
            state_q <= IDLE;
            waddr_q <= '0;
            word_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            prime_q <= 1'b0;
            done_q  <= 1'b0;
            bsel_q  <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            word_q  <= word_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            prime_q <= prime_d;
            done_q  <= done_d;
            bsel_q  <= bsel_d;
        end
    end

    assign o_bit_read_mem = valid_q & shift_q[0];
    assign o_bit_valid    = valid_q;
    assign o_capture_done = done_q;
    assign o_busy         = (state_q == CAPTURE) || (state_q == READ);
    assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_dsp_capture_mem.sv
// Directed bench for dsp_capture_mem: capture known frames, deserialize the readout, compare.
interface mem_rw_if;
    logic              wclk;
    logic [15:0][5:0]  data;
endinterface

interface mem_mon_if;
    logic clk_mon;
    logic data_mon;
endinterface

module tb_dsp_capture_mem;

    localparam int FL = 128;
    localparam int MW = 96;

    mem_rw_if  rw();
    mem_mon_if mon();

    logic clk;
    logic rstb, cap, rd;
    logic bit_read, bit_valid, cap_done, busy;
    dsp_capture_mem_pkg::state_e dbg_state;

    int n_chk  = 0;
    int n_pass = 0;

    logic [MW-1:0] exp_frame [FL];
    logic [MW-1:0] exp_q [$];

    assign clk          = rw.wclk;
    assign mon.clk_mon  = rw.wclk;
    assign mon.data_mon = bit_read;

    dsp_capture_mem u_dut (
        .i_clk_dig_mem   (rw.wclk),
        .i_rstb          (rstb),
        .i_dat_mem       (rw.data),
        .i_capture_start (cap),
        .i_read_start    (rd),
        .o_bit_read_mem  (bit_read),
        .o_bit_valid     (bit_valid),
        .o_capture_done  (cap_done),
        .o_busy          (busy),
        .o_dbg_state     (dbg_state)
    );

    initial rw.wclk = 1'b0;
    always #5 rw.wclk = ~rw.wclk;

    task automatic check(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [MW-1:0] ramp_word(input int k);
        logic [MW-1:0] r;
        for (int w = 0; w < 16; w++) r[w*6 +: 6] = 6'(k % 64);
        return r;
    endfunction

    function automatic logic [MW-1:0] bank_word(input int k);
        case (k)
            31:      return 96'hDEADBEEF_01234567_89ABCDEF;
            32:      return 96'h13579BDF_2468ACE0_F0E1D2C3;
            63:      return 96'hFFFFFFFF_00000000_FFFFFFFF;
            64:      return 96'h00000000_FFFFFFFF_00000001;
            95:      return 96'h80000000_00000000_00000000;
            96:      return 96'hA5A5A5A5_5A5A5A5A_C3C3C3C3;
            default: return {12{8'(k)}};
        endcase
    endfunction

    task automatic pulse_read();
        @(posedge clk); #1 rd = 1'b1;
        @(posedge clk); #1 rd = 1'b0;
    endtask

    // Drives exp_frame into the DUT as one capture; a stray read pulse mid-capture must be ignored.
    task automatic capture_frame(input string tag);
        int low;
        low = 0;
        @(posedge clk); #1 cap = 1'b1;
        @(posedge clk); #1 cap = 1'b0;
        for (int k = 0; k < FL; k++) begin
            rw.data = exp_frame[k];
            rd      = (k == 10);
            @(negedge clk);
            if (!cap_done) low++;
            if (k == 0) check({tag, "_busy"}, busy, 1'b1);
            @(posedge clk); #1;
        end
        rd      = 1'b0;
        rw.data = {MW/4{4'h5}};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cap_done) break;
            low++;
        end
        check({tag, "_done_low_cycles"}, low, FL + 1);
    endtask

    task automatic read_frame(input string tag, input bit inject_cap, output int ones);
        int lat, gaps;
        logic [MW-1:0] w;
        ones = 0;
        gaps = 0;
        w    = '0;
        for (int k = 0; k < FL; k++) exp_q.push_back(exp_frame[k]);
        pulse_read();
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            if (bit_valid) break;
            lat++;
        end
        check({tag, "_latency"}, lat, 2);
        if (lat >= 10) begin
            exp_q.delete();
            return;
        end
        for (int k = 0; k < FL; k++) begin
            for (int b = 0; b < MW; b++) begin
                if (!bit_valid) gaps++;
                w[b] = mon.data_mon;
                if (mon.data_mon) ones++;
                if (inject_cap && k == 3) cap = (b == 0);
                @(negedge clk);
            end
            check($sformatf("%s_w%0d", tag, k), w, exp_q.pop_front());
        end
        cap = 1'b0;
        check({tag, "_gaps"}, gaps, 0);
        check({tag, "_valid_end"}, bit_valid, 1'b0);
        check({tag, "_bit_idle"}, bit_read, 1'b0);
        check({tag, "_done_kept"}, cap_done, 1'b1);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    task automatic idle_read_ignored(input string tag);
        int seen;
        seen = 0;
        pulse_read();
        repeat (6) begin
            @(negedge clk);
            if (bit_valid) seen++;
        end
        check({tag, "_no_valid"}, seen, 0);
        check({tag, "_done"}, cap_done, 1'b0);
        check({tag, "_state"}, dbg_state, dsp_capture_mem_pkg::IDLE);
    endtask

    initial begin
        int ones;
        rstb    = 1'b0;
        cap     = 1'b0;
        rd      = 1'b0;
        rw.data = '0;
        repeat (3) @(negedge clk);
        check("rst_bit", bit_read, 1'b0);
        check("rst_valid", bit_valid, 1'b0);
        check("rst_done", cap_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        rstb = 1'b1;
        idle_read_ignored("idle");

        for (int k = 0; k < FL; k++) exp_frame[k] = ramp_word(k);
        capture_frame("ramp");
        read_frame("ramp", 1'b0, ones);
        read_frame("reread", 1'b1, ones);

        for (int k = 0; k < FL; k++) exp_frame[k] = (k == 0) ? 96'h1 : '0;
        capture_frame("bitord");
        read_frame("bitord", 1'b0, ones);
        check("bitord_ones", ones, 1);

        for (int k = 0; k < FL; k++) exp_frame[k] = bank_word(k);
        capture_frame("bank");
        read_frame("bank", 1'b0, ones);

        pulse_read();
        repeat (40) @(negedge clk);
        check("midrd_valid", bit_valid, 1'b1);
        #2 rstb = 1'b0;
        #1;
        check("midrd_rst_bit", bit_read, 1'b0);
        check("midrd_rst_valid", bit_valid, 1'b0);
        check("midrd_rst_done", cap_done, 1'b0);
        check("midrd_rst_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rstb = 1'b1;
        idle_read_ignored("postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
